// File: rtl/uart_pos_cmd_rx_pkg.sv
// Shared constants, state encodings and hex helpers for the UART position command receiver.
package uart_pos_cmd_rx_pkg;

   localparam int unsigned OS_RATE = 16;

   localparam logic [7:0] CH_P  = 8'h50;
   localparam logic [7:0] CH_p  = 8'h70;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_0  = 8'h30;
   localparam logic [7:0] CH_9  = 8'h39;
   localparam logic [7:0] CH_A  = 8'h41;
   localparam logic [7:0] CH_F  = 8'h46;
   localparam logic [7:0] CH_a  = 8'h61;
   localparam logic [7:0] CH_f  = 8'h66;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {PS_WAIT_P, PS_GET_X, PS_GET_Y, PS_WAIT_END} parse_state_t;

   function automatic logic is_hex(input logic [7:0] c);
      return ((c >= CH_0) && (c <= CH_9)) ||
             ((c >= CH_A) && (c <= CH_F)) ||
             ((c >= CH_a) && (c <= CH_f));
   endfunction

   function automatic logic [3:0] hex_val(input logic [7:0] c);
      logic [3:0] v;
      v = 4'd0;
      if ((c >= CH_0) && (c <= CH_9))      v = 4'(c - CH_0);
      else if ((c >= CH_A) && (c <= CH_F)) v = 4'(c - CH_A + 8'd10);
      else if ((c >= CH_a) && (c <= CH_f)) v = 4'(c - CH_a + 8'd10);
      return v;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, 16x oversample tick divider and start/data/stop FSM.
module uart_rx_byte
   import uart_pos_cmd_rx_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err
);

   localparam int unsigned OS_DIV_RAW = CLK_FREQ / (BAUD * OS_RATE);
   localparam int unsigned OS_DIV     = (OS_DIV_RAW < 1) ? 1 : OS_DIV_RAW;
   localparam int unsigned DIV_W      = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
   localparam logic [3:0]  HALF_LAST  = 4'(OS_RATE / 2 - 1);
   localparam logic [3:0]  FULL_LAST  = 4'(OS_RATE - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             tick_c;
   logic             rx_meta, rx_sync;

   rx_state_t state, state_n;
   logic [3:0] tick_cnt, tick_cnt_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [7:0] shift, shift_n;
   logic       valid_c, ferr_c;

   assign tick_c = (div_cnt == DIV_W'(OS_DIV - 1));

   // Free-running oversample divider and two-flop synchroniser
   always_ff @(posedge CLK) begin
      if (reset) begin
         div_cnt <= '0;
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state     <= RX_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         tick_cnt  <= tick_cnt_n;
         bit_cnt   <= bit_cnt_n;
         shift     <= shift_n;
         rx_valid  <= valid_c;
         frame_err <= ferr_c;
         if (valid_c) rx_data <= shift;
      end
   end

   always_comb begin
      state_n    = state;
      tick_cnt_n = tick_cnt;
      bit_cnt_n  = bit_cnt;
      shift_n    = shift;
      valid_c    = 1'b0;
      ferr_c     = 1'b0;
      if (tick_c) begin
         unique case (state)
            RX_IDLE: begin
               if (!rx_sync) begin
                  state_n    = RX_START;
                  tick_cnt_n = '0;
               end
            end
            RX_START: begin
               tick_cnt_n = tick_cnt + 4'd1;
               if (tick_cnt == HALF_LAST) begin
                  tick_cnt_n = '0;
                  bit_cnt_n  = '0;
                  state_n    = rx_sync ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA: begin
               tick_cnt_n = tick_cnt + 4'd1;
               if (tick_cnt == FULL_LAST) begin
                  tick_cnt_n = '0;
                  shift_n    = {rx_sync, shift[7:1]};
                  bit_cnt_n  = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state_n = RX_STOP;
               end
            end
            RX_STOP: begin
               tick_cnt_n = tick_cnt + 4'd1;
               if (tick_cnt == FULL_LAST) begin
                  tick_cnt_n = '0;
                  valid_c    = rx_sync;
                  ferr_c     = !rx_sync;
                  state_n    = RX_IDLE;
               end
            end
            default: state_n = RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_pos_cmd_rx.sv
// UART position command receiver: parses 'P' x y <CR|LF> and commits 4-bit grid coordinates.
module uart_pos_cmd_rx
   import uart_pos_cmd_rx_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] position_x,
   output logic [7:0] position_y,
   output logic       pos_update,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       cmd_err
);

   parse_state_t pstate, pstate_n;
   logic [3:0]   x_tmp, x_tmp_n;
   logic [3:0]   y_tmp, y_tmp_n;
   logic         commit_c, cmd_err_c;

   uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
      .CLK       (CLK),
      .reset     (reset),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   always_ff @(posedge CLK) begin
      if (reset) begin
         pstate     <= PS_WAIT_P;
         x_tmp      <= '0;
         y_tmp      <= '0;
         position_x <= '0;
         position_y <= '0;
         pos_update <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         pstate     <= pstate_n;
         x_tmp      <= x_tmp_n;
         y_tmp      <= y_tmp_n;
         pos_update <= commit_c;
         cmd_err    <= cmd_err_c;
         if (commit_c) begin
            position_x <= {4'b0, x_tmp};
            position_y <= {4'b0, y_tmp};
         end
      end
   end

   // A command start byte resyncs from any state; a framing error silently drops the command
   always_comb begin
      pstate_n  = pstate;
      x_tmp_n   = x_tmp;
      y_tmp_n   = y_tmp;
      commit_c  = 1'b0;
      cmd_err_c = 1'b0;
      if (frame_err) begin
         pstate_n = PS_WAIT_P;
      end else if (rx_valid) begin
         if ((rx_data == CH_P) || (rx_data == CH_p)) begin
            pstate_n = PS_GET_X;
         end else begin
            unique case (pstate)
               PS_WAIT_P: pstate_n = PS_WAIT_P;
               PS_GET_X: begin
                  if (is_hex(rx_data)) begin
                     x_tmp_n  = hex_val(rx_data);
                     pstate_n = PS_GET_Y;
                  end else begin
                     cmd_err_c = 1'b1;
                     pstate_n  = PS_WAIT_P;
                  end
               end
               PS_GET_Y: begin
                  if (is_hex(rx_data)) begin
                     y_tmp_n  = hex_val(rx_data);
                     pstate_n = PS_WAIT_END;
                  end else begin
                     cmd_err_c = 1'b1;
                     pstate_n  = PS_WAIT_P;
                  end
               end
               PS_WAIT_END: begin
                  if ((rx_data == CH_CR) || (rx_data == CH_LF)) commit_c  = 1'b1;
                  else                                          cmd_err_c = 1'b1;
                  pstate_n = PS_WAIT_P;
               end
               default: pstate_n = PS_WAIT_P;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_pos_cmd_rx.sv
// Directed bench for uart_pos_cmd_rx at 16 CLK per bit (OS_DIV=1).
module tb_uart_pos_cmd_rx;

   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] position_x, position_y, rx_data;
   logic       pos_update, rx_valid, frame_err, cmd_err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0;
   int rv_cnt = 0, pu_cnt = 0, ce_cnt = 0, fe_cnt = 0;
   int last_rv = -1, last_pu = -1;
   int rv0, pu0, ce0, fe0;

   uart_pos_cmd_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .rx         (rx),
      .position_x (position_x),
      .position_y (position_y),
      .pos_update (pos_update),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
      .cmd_err    (cmd_err)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (rx_valid)   begin rv_cnt <= rv_cnt + 1; last_rv <= cyc; end
      if (pos_update) begin pu_cnt <= pu_cnt + 1; last_pu <= cyc; end
      if (cmd_err)    ce_cnt <= ce_cnt + 1;
      if (frame_err)  fe_cnt <= fe_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      repeat (16) @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
      send_bit(1'b1);
      send_bit(1'b1);
   endtask

   task automatic snap();
      @(negedge CLK);
      rv0 = rv_cnt; pu0 = pu_cnt; ce0 = ce_cnt; fe0 = fe_cnt;
      @(posedge CLK); #1;
   endtask

   task automatic settle();
      repeat (4) @(negedge CLK);
   endtask

   initial begin
      repeat (5) @(posedge CLK);
      #1;
      check("rst_pos_x", 32'(position_x), 32'h0);
      check("rst_pos_y", 32'(position_y), 32'h0);
      check("rst_rx_data", 32'(rx_data), 32'h0);
      check("rst_pulses", {28'h0, pos_update, rx_valid, frame_err, cmd_err}, 32'h0);
      reset = 1'b0;
      repeat (3) @(posedge CLK);
      #1;

      // "P3A" CR
      snap();
      send_byte(8'h50, 1'b1); send_byte(8'h33, 1'b1);
      send_byte(8'h41, 1'b1); send_byte(8'h0D, 1'b1);
      settle();
      check("p3a_rv_count", 32'(rv_cnt - rv0), 32'd4);
      check("p3a_pu_count", 32'(pu_cnt - pu0), 32'd1);
      check("p3a_pos_x", 32'(position_x), 32'h03);
      check("p3a_pos_y", 32'(position_y), 32'h0A);
      check("p3a_pu_latency", 32'(last_pu - last_rv), 32'd1);
      check("p3a_rx_data", 32'(rx_data), 32'h0D);

      // "pf0" LF, then aborted "P12X"
      send_byte(8'h70, 1'b1); send_byte(8'h66, 1'b1);
      send_byte(8'h30, 1'b1); send_byte(8'h0A, 1'b1);
      settle();
      check("pf0_pos_x", 32'(position_x), 32'h0F);
      check("pf0_pos_y", 32'(position_y), 32'h00);
      snap();
      send_byte(8'h50, 1'b1); send_byte(8'h31, 1'b1);
      send_byte(8'h32, 1'b1); send_byte(8'h58, 1'b1);
      settle();
      check("p12x_cmd_err", 32'(ce_cnt - ce0), 32'd1);
      check("p12x_no_update", 32'(pu_cnt - pu0), 32'd0);
      check("p12x_pos_x", 32'(position_x), 32'h0F);
      check("p12x_pos_y", 32'(position_y), 32'h00);

      // 3-CLK start glitch
      snap();
      rx = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      rx = 1'b1;
      repeat (40) @(posedge CLK);
      #1;
      check("glitch_rv", 32'(rv_cnt - rv0), 32'd0);
      check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
      send_byte(8'h50, 1'b1); send_byte(8'h35, 1'b1);
      send_byte(8'h35, 1'b1); send_byte(8'h0D, 1'b1);
      settle();
      check("p55_pos_x", 32'(position_x), 32'h05);
      check("p55_pos_y", 32'(position_y), 32'h05);
      check("p55_rv_count", 32'(rv_cnt - rv0), 32'd4);

      // Framing errors
      snap();
      send_byte(8'h41, 1'b0);
      settle();
      check("ferr_count", 32'(fe_cnt - fe0), 32'd1);
      check("ferr_no_rv", 32'(rv_cnt - rv0), 32'd0);
      snap();
      send_byte(8'h50, 1'b1); send_byte(8'h37, 1'b1);
      send_byte(8'h42, 1'b0);
      send_byte(8'h37, 1'b1); send_byte(8'h0D, 1'b1);
      settle();
      check("ferr_cmd_fe", 32'(fe_cnt - fe0), 32'd1);
      check("ferr_cmd_no_update", 32'(pu_cnt - pu0), 32'd0);
      check("ferr_cmd_no_cmd_err", 32'(ce_cnt - ce0), 32'd0);
      check("ferr_cmd_pos_x", 32'(position_x), 32'h05);
      check("ferr_cmd_pos_y", 32'(position_y), 32'h05);

      // Resync: "PP2" "P4" "1" CR
      snap();
      send_byte(8'h50, 1'b1); send_byte(8'h50, 1'b1); send_byte(8'h32, 1'b1);
      send_byte(8'h50, 1'b1); send_byte(8'h34, 1'b1);
      send_byte(8'h31, 1'b1); send_byte(8'h0D, 1'b1);
      settle();
      check("resync_cmd_err", 32'(ce_cnt - ce0), 32'd0);
      check("resync_pu_count", 32'(pu_cnt - pu0), 32'd1);
      check("resync_pos_x", 32'(position_x), 32'h04);
      check("resync_pos_y", 32'(position_y), 32'h01);

      // Reset in the middle of the data bits of 'P'
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      reset = 1'b1;
      @(posedge CLK);
      #1;
      check("midrst_pos_x", 32'(position_x), 32'h0);
      check("midrst_pos_y", 32'(position_y), 32'h0);
      check("midrst_rx_data", 32'(rx_data), 32'h0);
      reset = 1'b0;
      rx = 1'b1;
      repeat (48) @(posedge CLK);
      #1;
      check("postrst_pos_x", 32'(position_x), 32'h0);
      check("postrst_pulses", {28'h0, pos_update, rx_valid, frame_err, cmd_err}, 32'h0);
      snap();
      send_byte(8'h50, 1'b1); send_byte(8'h39, 1'b1);
      send_byte(8'h38, 1'b1); send_byte(8'h0D, 1'b1);
      settle();
      check("p98_pos_x", 32'(position_x), 32'h09);
      check("p98_pos_y", 32'(position_y), 32'h08);
      check("p98_pu_count", 32'(pu_cnt - pu0), 32'd1);
      check("p98_no_fe", 32'(fe_cnt - fe0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
